// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the common data bus: widths, requester ids,
// the CDB lane record and a request population counter.
package cpu_pkg;

    localparam int NUM_REQ = 4;
    localparam int NUM_CDB = 2;
    localparam int TAG_W   = 4;
    localparam int DATA_W  = 16;
    localparam int PTR_W   = 2;

    localparam logic [PTR_W-1:0] REQ_FXU0 = 2'd0;
    localparam logic [PTR_W-1:0] REQ_FXU1 = 2'd1;
    localparam logic [PTR_W-1:0] REQ_LSU  = 2'd2;
    localparam logic [PTR_W-1:0] REQ_BR   = 2'd3;

    // Lane count in the width of a request population count.
    localparam logic [PTR_W:0] NUM_CDB_CNT = (PTR_W+1)'(NUM_CDB);

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] value;
        logic [PTR_W-1:0]  src;
    } cdb_lane_t;

    function automatic logic [PTR_W:0] count_valid(input logic [NUM_REQ-1:0] v);
        logic [PTR_W:0] cnt;
        cnt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cnt = cnt + {{PTR_W{1'b0}}, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/rr_multi_grant.sv
// Combinational circular picker: grants up to NUM_CDB valid requesters in
// scan order starting at rr_ptr, one lane per grant, and proposes the next pointer.
module rr_multi_grant #(
    parameter int NUM_REQ = 4,
    parameter int NUM_CDB = 2,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [PTR_W-1:0]               rr_ptr,
    output logic [NUM_REQ-1:0]             grant,
    output logic [NUM_CDB-1:0][PTR_W-1:0]  lane_src,
    output logic [NUM_CDB-1:0]             lane_valid,
    output logic [PTR_W-1:0]               next_ptr
);

    logic [NUM_REQ-1:0] avail_s;
    logic               found_s;
    logic [PTR_W-1:0]   idx_s;

    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end else begin
            s = s;
        end
        return PTR_W'(s);
    endfunction

    // Each lane takes the first still-available requester in scan order.
    always_comb begin
        grant      = '0;
        lane_src   = '0;
        lane_valid = '0;
        next_ptr   = rr_ptr;
        avail_s    = req_valid;
        found_s    = 1'b0;
        idx_s      = '0;
        for (int k = 0; k < NUM_CDB; k++) begin
            found_s = 1'b0;
            for (int off = 0; off < NUM_REQ; off++) begin
                idx_s = wrap_idx(rr_ptr, off);
                if (!found_s && avail_s[idx_s]) begin
                    found_s        = 1'b1;
                    avail_s[idx_s] = 1'b0;
                    grant[idx_s]   = 1'b1;
                    lane_src[k]    = idx_s;
                    lane_valid[k]  = 1'b1;
                    next_ptr       = wrap_idx(idx_s, 1);
                end else begin
                    found_s = found_s;
                end
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: round-robin multi-lane grant of functional-unit results onto
// registered broadcast lanes, with flush handling and a saturating stall counter.
module cdb_arbiter
    import cpu_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
    input  logic [NUM_REQ*DATA_W-1:0] req_value,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_CDB-1:0]        cdb_valid,
    output logic [NUM_CDB*TAG_W-1:0]  cdb_index,
    output logic [NUM_CDB*DATA_W-1:0] cdb_value,
    output logic [NUM_CDB*PTR_W-1:0]  cdb_src,
    output logic [15:0]               stall_cycles
);

    logic [NUM_REQ-1:0]            grant_s;
    logic [NUM_CDB-1:0][PTR_W-1:0] lane_src_s;
    logic [NUM_CDB-1:0]            lane_valid_s;
    logic [PTR_W-1:0]              next_ptr_s;
    logic [PTR_W-1:0]              rr_ptr_r;
    logic                          grant_en_s;
    logic [PTR_W:0]                nvalid_s;
    cdb_lane_t [NUM_CDB-1:0]       lane_r;
    cdb_lane_t [NUM_CDB-1:0]       lane_nxt_s;
    logic [15:0]                   stall_r;
    logic [TAG_W-1:0]              tag_arr_s [NUM_REQ];
    logic [DATA_W-1:0]             value_arr_s [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign tag_arr_s[i]   = req_tag[i*TAG_W +: TAG_W];
        assign value_arr_s[i] = req_value[i*DATA_W +: DATA_W];
    end

    rr_multi_grant #(
        .NUM_REQ (NUM_REQ),
        .NUM_CDB (NUM_CDB),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req_valid  (req_valid),
        .rr_ptr     (rr_ptr_r),
        .grant      (grant_s),
        .lane_src   (lane_src_s),
        .lane_valid (lane_valid_s),
        .next_ptr   (next_ptr_s)
    );

    // Grants are suppressed during reset and flush; nothing transfers then.
    assign grant_en_s = rst_n & ~flush;
    assign req_ready  = grant_s & {NUM_REQ{grant_en_s}};
    assign nvalid_s   = count_valid(req_valid);

    // Next lane contents; payload is held on lanes that go invalid.
    always_comb begin
        lane_nxt_s = lane_r;
        for (int k = 0; k < NUM_CDB; k++) begin
            if (lane_valid_s[k] && grant_en_s) begin
                lane_nxt_s[k].valid = 1'b1;
                lane_nxt_s[k].tag   = tag_arr_s[lane_src_s[k]];
                lane_nxt_s[k].value = value_arr_s[lane_src_s[k]];
                lane_nxt_s[k].src   = lane_src_s[k];
            end else begin
                lane_nxt_s[k].valid = 1'b0;
            end
        end
    end

    // Lane registers, round-robin pointer and saturating stall counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_r   <= '0;
            rr_ptr_r <= '0;
            stall_r  <= 16'h0000;
        end else begin
            lane_r <= lane_nxt_s;
            if ((grant_s != '0) && !flush) begin
                rr_ptr_r <= next_ptr_s;
            end
            if ((nvalid_s > NUM_CDB_CNT) && !flush && (stall_r != 16'hFFFF)) begin
                stall_r <= stall_r + 16'h0001;
            end
        end
    end

    for (genvar k = 0; k < NUM_CDB; k++) begin : g_lanes
        assign cdb_valid[k]                  = lane_r[k].valid;
        assign cdb_index[k*TAG_W +: TAG_W]   = lane_r[k].tag;
        assign cdb_value[k*DATA_W +: DATA_W] = lane_r[k].value;
        assign cdb_src[k*PTR_W +: PTR_W]     = lane_r[k].src;
    end

    assign stall_cycles = stall_r;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter: handshake, lane mapping,
// round-robin order, flush, asynchronous reset and stall counter saturation.
module tb_cdb_arbiter;
    import cpu_pkg::*;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      flush;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*TAG_W-1:0]  req_tag;
    logic [NUM_REQ*DATA_W-1:0] req_value;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_CDB-1:0]        cdb_valid;
    logic [NUM_CDB*TAG_W-1:0]  cdb_index;
    logic [NUM_CDB*DATA_W-1:0] cdb_value;
    logic [NUM_CDB*PTR_W-1:0]  cdb_src;
    logic [15:0]               stall_cycles;

    logic [TAG_W-1:0]  tag_a [NUM_REQ];
    logic [DATA_W-1:0] val_a [NUM_REQ];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_tag[i*TAG_W +: TAG_W]     = tag_a[i];
            req_value[i*DATA_W +: DATA_W] = val_a[i];
        end
    end

    cdb_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .req_valid    (req_valid),
        .req_tag      (req_tag),
        .req_value    (req_value),
        .req_ready    (req_ready),
        .cdb_valid    (cdb_valid),
        .cdb_index    (cdb_index),
        .cdb_value    (cdb_value),
        .cdb_src      (cdb_src),
        .stall_cycles (stall_cycles)
    );

    task automatic chk(input string name, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        req_valid = 4'b1111;
        for (int i = 0; i < NUM_REQ; i++) begin
            tag_a[i] = 4'h0;
            val_a[i] = 16'h0000;
        end
        #12;
        chk("reset_ready", 16'(req_ready), 16'h0000);
        chk("reset_valid", 16'(cdb_valid), 16'h0000);
        chk("reset_index", 16'(cdb_index), 16'h0000);
        chk("reset_value0", cdb_value[15:0], 16'h0000);
        chk("reset_src", 16'(cdb_src), 16'h0000);
        chk("reset_stall", stall_cycles, 16'h0000);
        req_valid = 4'b0000;
        #4 rst_n = 1'b1;
        tick();

        // Single request from fxu_0
        tag_a[0] = 4'd5; val_a[0] = 16'h1234; req_valid = 4'b0001;
        #2 chk("single_ready", 16'(req_ready), 16'h0001);
        tick(); req_valid = 4'b0000;
        chk("single_valid", 16'(cdb_valid), 16'h0001);
        chk("single_idx0", 16'(cdb_index[3:0]), 16'h0005);
        chk("single_val0", cdb_value[15:0], 16'h1234);
        chk("single_src0", 16'(cdb_src[1:0]), 16'h0000);

        // Pointer now 1: three requesters, grants 1 and 2
        tag_a[0] = 4'd1; tag_a[1] = 4'd2; tag_a[2] = 4'd3;
        val_a[0] = 16'h00A1; val_a[1] = 16'h00A2; val_a[2] = 16'h00A3;
        req_valid = 4'b0111;
        #2 chk("ptr1_ready", 16'(req_ready), 16'h0006);
        tick(); req_valid = 4'b0000;
        chk("ptr1_valid", 16'(cdb_valid), 16'h0003);
        chk("ptr1_src0", 16'(cdb_src[1:0]), 16'h0001);
        chk("ptr1_idx0", 16'(cdb_index[3:0]), 16'h0002);
        chk("ptr1_val1", cdb_value[31:16], 16'h00A3);
        chk("ptr1_src1", 16'(cdb_src[3:2]), 16'h0002);
        chk("ptr1_stall", stall_cycles, 16'h0001);

        // Wrap-around from pointer 3
        tag_a[3] = 4'd9; val_a[3] = 16'hBEEF; req_valid = 4'b1001;
        #2 chk("wrap_ready", 16'(req_ready), 16'h0009);
        tick(); req_valid = 4'b0000;
        chk("wrap_valid", 16'(cdb_valid), 16'h0003);
        chk("wrap_src0", 16'(cdb_src[1:0]), 16'h0003);
        chk("wrap_val0", cdb_value[15:0], 16'hBEEF);
        chk("wrap_src1", 16'(cdb_src[3:2]), 16'h0000);
        chk("wrap_idx1", 16'(cdb_index[7:4]), 16'h0001);
        chk("wrap_stall", stall_cycles, 16'h0001);

        // Pointer now 1: lone branch result, lane1 payload held
        req_valid = 4'b1000;
        #2 chk("br_ready", 16'(req_ready), 16'h0008);
        tick(); req_valid = 4'b0000;
        chk("br_valid", 16'(cdb_valid), 16'h0001);
        chk("br_src0", 16'(cdb_src[1:0]), 16'h0003);
        chk("hold_idx1", 16'(cdb_index[7:4]), 16'h0001);

        // Pointer 0: all four valid, duplicate tags on lsu and branch
        tag_a[0] = 4'd4; tag_a[1] = 4'd5; tag_a[2] = 4'd6; tag_a[3] = 4'd6;
        val_a[0] = 16'h1000; val_a[1] = 16'h1001; val_a[2] = 16'h1002; val_a[3] = 16'h1003;
        req_valid = 4'b1111;
        #2 chk("all_c1_ready", 16'(req_ready), 16'h0003);
        tick(); req_valid = 4'b1100;
        chk("all_c1_valid", 16'(cdb_valid), 16'h0003);
        chk("all_c1_src0", 16'(cdb_src[1:0]), 16'h0000);
        chk("all_c1_src1", 16'(cdb_src[3:2]), 16'h0001);
        chk("all_c1_idx1", 16'(cdb_index[7:4]), 16'h0005);
        chk("all_c1_stall", stall_cycles, 16'h0002);
        #2 chk("all_c2_ready", 16'(req_ready), 16'h000C);
        tick(); req_valid = 4'b0000;
        chk("all_c2_valid", 16'(cdb_valid), 16'h0003);
        chk("all_c2_src0", 16'(cdb_src[1:0]), 16'h0002);
        chk("all_c2_idx", 16'(cdb_index), 16'h0066);
        chk("all_c2_val1", cdb_value[31:16], 16'h1003);
        chk("all_c2_stall", stall_cycles, 16'h0002);

        // Idle cycle
        #2 chk("idle_ready", 16'(req_ready), 16'h0000);
        tick();
        chk("idle_valid", 16'(cdb_valid), 16'h0000);

        // Flush with all requests pending
        flush = 1'b1; req_valid = 4'b1111;
        #2 chk("flush_ready", 16'(req_ready), 16'h0000);
        tick(); flush = 1'b0;
        chk("flush_valid", 16'(cdb_valid), 16'h0000);
        chk("flush_stall", stall_cycles, 16'h0002);
        #2 chk("postflush_ready", 16'(req_ready), 16'h0003);
        tick();
        chk("postflush_valid", 16'(cdb_valid), 16'h0003);
        chk("postflush_stall", stall_cycles, 16'h0003);

        // Asynchronous reset between edges while both lanes are busy
        #2 rst_n = 1'b0;
        #1;
        chk("areset_valid", 16'(cdb_valid), 16'h0000);
        chk("areset_stall", stall_cycles, 16'h0000);
        chk("areset_ready", 16'(req_ready), 16'h0000);
        req_valid = 4'b0000;
        #2 rst_n = 1'b1;
        tick();

        // Saturation of the stall counter
        req_valid = 4'b1111;
        #2 chk("sat_ptr_ready", 16'(req_ready), 16'h0003);
        repeat (65534) @(posedge clk);
        #1 chk("sat_fffe", stall_cycles, 16'hFFFE);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("sat_ffff", stall_cycles, 16'hFFFF);
        end
        req_valid = 4'b0000;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the common data bus (CDB) between the functional units fxu_0, fxu_1, lsu and branch.
- Each unit offers one completed result, as a ROB index plus a 16-bit value, through a valid/ready handshake.
- Each cycle the arbiter grants up to NUM_CDB results in round-robin order and registers them onto the CDB lanes.
- The ROB and the reservation stations consume the CDB lanes as cdb_valid / indices / new_values.

Parameters:
- NUM_REQ, 4: number of requesters. Index 0 = fxu_0, 1 = fxu_1, 2 = lsu, 3 = branch.
- NUM_CDB, 2: number of CDB broadcast lanes. Legal range 1..NUM_REQ.
- TAG_W, 4: ROB index width.
- DATA_W, 16: result width.
- PTR_W, 2: width of the round-robin pointer, equal to clog2(NUM_REQ).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  pipeline flush (branch mispredict); synchronous.
- req_valid  in  NUM_REQ  per-requester result valid.
- req_tag  in  NUM_REQ*TAG_W  ROB index; requester i occupies bits [i*TAG_W +: TAG_W].
- req_value  in  NUM_REQ*DATA_W  result value; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  combinational grant; a transfer occurs when req_valid and req_ready are both high.
- cdb_valid  out  NUM_CDB  registered lane valid.
- cdb_index  out  NUM_CDB*TAG_W  registered ROB index per lane.
- cdb_value  out  NUM_CDB*DATA_W  registered value per lane.
- cdb_src  out  NUM_CDB*PTR_W  registered requester id per lane, for debug and tracing.
- stall_cycles  out  16  saturating count of cycles in which valid requests exceeded the lanes granted.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - cdb_valid=0, cdb_index=0, cdb_value=0, cdb_src=0.
  - rr_ptr=0, stall_cycles=0.
  - req_ready is forced to 0 while rst_n=0.
- Handshake:
  - A requester holds req_valid, req_tag and req_value stable until it sees req_ready high in the same cycle.
  - req_ready[i] may depend combinationally on req_valid and rr_ptr only, never on req_tag or req_value.
  - req_ready[i]=0 whenever req_valid[i]=0.
- Grant selection (combinational):
  - Scan requesters circularly, starting at rr_ptr: rr_ptr, rr_ptr+1, ... (mod NUM_REQ).
  - The first min(NUM_CDB, popcount(req_valid)) valid requesters are granted.
  - The k-th granted requester in scan order is assigned lane k (lane 0 first).
  - Unused lanes carry valid 0.
- Latency: a granted result appears on its lane on the next rising edge, exactly 1 cycle later, and is held there for exactly 1 cycle.
  - Lane valid is rewritten every cycle, so there is no back-pressure from the CDB side.
  - cdb_index, cdb_value and cdb_src keep their old contents when the lane is invalid.
- rr_ptr update:
  - If at least one grant occurs, rr_ptr becomes (id of the last granted requester + 1) mod NUM_REQ.
  - If there is no grant, rr_ptr is unchanged.
  - Fairness: any continuously valid requester is granted within ceil(NUM_REQ/NUM_CDB) cycles.
- stall_cycles: increments by 1 on each edge where popcount(req_valid) > NUM_CDB and flush=0. It saturates at 16'hFFFF.
- flush=1:
  - All req_ready are 0 that cycle (no grants).
  - cdb_valid becomes 0 on the next edge.
  - rr_ptr and stall_cycles are unchanged.
  - Requesters are flushed by their own control, not by this block.
- Simultaneous events:
  - flush together with requests: flush wins and nothing is granted.
  - Reset asserted mid-operation clears state immediately, including any result in flight on the CDB (it is lost).
- Boundary conditions:
  - NUM_CDB == NUM_REQ: every valid request is granted every cycle, and stall_cycles never increments.
  - Duplicate tags from two requesters are not checked; both are broadcast.
  - An all-zero req_valid produces cdb_valid=0 on the next edge.

Decomposition:
- Shared package (cpu_pkg) holds:
  - TAG_W, DATA_W, NUM_CDB.
  - Requester id constants: REQ_FXU0=0, REQ_FXU1=1, REQ_LSU=2, REQ_BR=3.
  - A cdb_lane typedef containing valid, tag, value and src.
- One sub-module, rr_multi_grant: a combinational circular multi-grant picker.
  - Inputs: req_valid, rr_ptr.
  - Outputs: grant vector, per-lane source id and valid, and the next pointer.
- The top level holds the registers, the flush/reset handling and the stall counter.

Test Plan:
- Reset then single request: after reset release, req_valid=4'b0001, tag=5, value=16'h1234.
  - Required: req_ready=4'b0001 in that cycle.
  - Next cycle: cdb_valid=2'b01, cdb_index lane0=5, cdb_value lane0=16'h1234, cdb_src lane0=0, rr_ptr=1.
- All four requesters valid and held for 2 cycles, rr_ptr=0:
  - Cycle 1 grants 0 and 1 (lane0=0, lane1=1), then rr_ptr=2.
  - Cycle 2 grants 2 and 3, then rr_ptr=0.
  - stall_cycles increments on the first cycle only, because the granted requesters drop valid after being accepted.
- Wrap-around: rr_ptr=3, req_valid=4'b1001.
  - Required: lane0=src 3, lane1=src 0, next rr_ptr=1.
- Flush: req_valid=4'b1111 with flush=1.
  - Required: req_ready=0, cdb_valid=0 next edge, rr_ptr and stall_cycles unchanged.
- Async reset mid-burst: drop rst_n between clock edges while cdb_valid=2'b11.
  - Required: cdb_valid=0 and stall_cycles=0 immediately, without waiting for a clock edge.
- Saturation: preload or force stall_cycles=16'hFFFE, then hold 4 valid requests for 3 cycles.
  - Required: the counter reaches 16'hFFFF and stays there.
